// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg
// Shared definitions for the DAC SPI loopback receiver: frame geometry,
// receiver FSM states and the AD5662 power-down codes carried in PD1/PD0.
package dac_spi_pkg;

   localparam int FRAME_BITS = 24;   // falling SCLK edges per write frame
   localparam int DATA_BITS  = 16;   // DAC code width, frame bits [15:0]
   localparam int PD_LSB     = 16;   // PD0 position, PD1 is PD_LSB+1

   typedef enum logic [1:0] {
      IDLE    = 2'd0,   // waiting for SYNC to fall
      SHIFT   = 2'd1,   // collecting data bits
      DONE    = 2'd2,   // frame complete, waiting for SYNC to rise
      LOCKOUT = 2'd3    // discarding a frame already in flight
   } rx_state_t;

   typedef enum logic [1:0] {
      PD_NORMAL   = 2'b00,
      PD_1K       = 2'b01,
      PD_100K     = 2'b10,
      PD_TRISTATE = 2'b11
   } pd_mode_t;

endpackage

// File: rtl/spi_input_sync.sv
// spi_input_sync
// Multi-bit synchronizer for asynchronous SPI pins. Every bit goes through the
// same number of stages so related pins stay mutually aligned. A registered
// previous-value stage provides edge detection; level, rise and fall are all
// registered and refer to the same sample, so they can be used together.
//
// Ports:
//   dataclk  - destination clock
//   reset    - synchronous active-high reset (flops load RESET_VAL)
//   async_in - raw asynchronous inputs
//   level    - synchronized level of each bit
//   rise     - one-cycle pulse, bit went 0 -> 1 (aligned with level)
//   fall     - one-cycle pulse, bit went 1 -> 0 (aligned with level)
module spi_input_sync #(
   parameter int               WIDTH     = 3,
   parameter int               STAGES    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             dataclk,
   input  logic             reset,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   // stage_reg[0] takes the raw pins; stage_reg[STAGES-1] is the settled value.
   logic [STAGES-1:0][WIDTH-1:0] stage_reg;
   logic [WIDTH-1:0]             prev_reg;
   logic [WIDTH-1:0]             rise_reg;
   logic [WIDTH-1:0]             fall_reg;
   logic [WIDTH-1:0]             sync_bits;
   logic [WIDTH-1:0]             rise_next;
   logic [WIDTH-1:0]             fall_next;

   assign sync_bits = stage_reg[STAGES-1];

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_edge
         assign rise_next[gi] =  sync_bits[gi] & ~prev_reg[gi];
         assign fall_next[gi] = ~sync_bits[gi] &  prev_reg[gi];
      end
   endgenerate

   always_ff @(posedge dataclk) begin
      if (reset) begin
         stage_reg <= {STAGES{RESET_VAL}};
         prev_reg  <= RESET_VAL;
         rise_reg  <= '0;
         fall_reg  <= '0;
      end else begin
         stage_reg <= {stage_reg[STAGES-2:0], async_in};
         prev_reg  <= sync_bits;
         rise_reg  <= rise_next;
         fall_reg  <= fall_next;
      end
   end

   assign level = prev_reg;
   assign rise  = rise_reg;
   assign fall  = fall_reg;

endmodule

// File: rtl/dac_spi_frame_receiver.sv
// dac_spi_frame_receiver
// Responder end of the DAC output SPI link, used as an on-chip loopback
// monitor. Decodes AD5662-style 24-bit write frames (SYNC/SCLK/DIN, data
// sampled on SCLK falling edges, MSB first) into the 16-bit DAC code and the
// two power-down bits.
//
// Ports:
//   dataclk        - system clock (only clock)
//   reset          - synchronous active-high reset
//   enable         - receiver enable; low holds the FSM idle, no strobes
//   spi_sync_in    - DAC_SYNC, active-low frame select (asynchronous)
//   spi_sclk_in    - DAC_SCLK (asynchronous)
//   spi_din_in     - DAC_DIN (asynchronous)
//   word_out       - frame bits [15:0] of last complete frame (offset binary)
//   word_twos_comp - word_out with the MSB inverted
//   pd_out         - frame bits [17:16] of last complete frame
//   word_valid     - one-cycle pulse when word_out/pd_out update
//   abort_err      - one-cycle pulse, SYNC rose before the last data bit
//   overrun_err    - one-cycle pulse per SCLK fall after the frame completed
//   frame_count    - number of valid frames, wraps
//   busy           - high while a frame is in progress (SHIFT or DONE)
module dac_spi_frame_receiver #(
   parameter int FRAME_BITS  = dac_spi_pkg::FRAME_BITS,
   parameter int SYNC_STAGES = 2
) (
   input  logic        dataclk,
   input  logic        reset,
   input  logic        enable,
   input  logic        spi_sync_in,
   input  logic        spi_sclk_in,
   input  logic        spi_din_in,
   output logic [15:0] word_out,
   output logic [15:0] word_twos_comp,
   output logic [1:0]  pd_out,
   output logic        word_valid,
   output logic        abort_err,
   output logic        overrun_err,
   output logic [15:0] frame_count,
   output logic        busy
);

   import dac_spi_pkg::*;

   localparam int                CNT_W    = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_BITS);

   // After reset the synchronizer holds its idle values for a few cycles
   // before the real pin level arrives. LOCKOUT must not trust a "SYNC high"
   // reading until that pipeline has been refilled from the pins.
   localparam int                SETTLE      = SYNC_STAGES + 2;
   localparam int                SETTLE_W    = $clog2(SETTLE + 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE);

   // Synchronized pins, bit order {sync, sclk, din}
   logic [2:0] pin_level;
   logic [2:0] pin_rise;
   logic [2:0] pin_fall;

   spi_input_sync #(
      .WIDTH     (3),
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (3'b110)
   ) u_input_sync (
      .dataclk  (dataclk),
      .reset    (reset),
      .async_in ({spi_sync_in, spi_sclk_in, spi_din_in}),
      .level    (pin_level),
      .rise     (pin_rise),
      .fall     (pin_fall)
   );

   logic sync_level;
   logic sync_rise;
   logic sync_fall;
   logic sclk_fall;
   logic din_level;

   assign sync_level = pin_level[2];
   assign sync_rise  = pin_rise[2];
   assign sync_fall  = pin_fall[2];
   assign sclk_fall  = pin_fall[1];
   assign din_level  = pin_level[0];

   rx_state_t             state_reg, state_next;
   logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
   logic [CNT_W-1:0]      bit_cnt_inc;
   logic [FRAME_BITS-1:0] shift_reg, shift_next;
   logic [SETTLE_W-1:0]   settle_reg, settle_next;
   logic [15:0]           word_reg, word_next;
   logic [15:0]           twos_reg, twos_next;
   logic [1:0]            pd_reg, pd_next;
   logic [15:0]           frame_count_reg, frame_count_next;
   logic                  valid_reg, valid_next;
   logic                  abort_reg, abort_next;
   logic                  overrun_reg, overrun_next;
   logic                  busy_reg, busy_next;

   assign bit_cnt_inc = bit_cnt_reg + CNT_W'(1);

   always_comb begin
      state_next       = state_reg;
      bit_cnt_next     = bit_cnt_reg;
      shift_next       = shift_reg;
      settle_next      = (settle_reg == '0) ? '0 : settle_reg - SETTLE_W'(1);
      word_next        = word_reg;
      twos_next        = twos_reg;
      pd_next          = pd_reg;
      frame_count_next = frame_count_reg;
      valid_next       = 1'b0;
      abort_next       = 1'b0;
      overrun_next     = 1'b0;

      if (!enable) begin
         // A frame already under way when the receiver is disabled must not
         // be picked up half-way once it is re-enabled.
         state_next = sync_level ? IDLE : LOCKOUT;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (sync_fall) begin
                  state_next   = SHIFT;
                  bit_cnt_next = '0;
                  shift_next   = '0;
               end
            end

            SHIFT: begin
               // A clock edge arriving together with SYNC rising is taken
               // first, so a frame completed on that edge is still valid.
               if (sclk_fall) begin
                  shift_next   = {shift_reg[FRAME_BITS-2:0], din_level};
                  bit_cnt_next = bit_cnt_inc;
               end
               if (sclk_fall && bit_cnt_inc == LAST_BIT) begin
                  word_next        = shift_next[DATA_BITS-1:0];
                  twos_next        = {~shift_next[DATA_BITS-1], shift_next[DATA_BITS-2:0]};
                  pd_next          = shift_next[PD_LSB+1:PD_LSB];
                  valid_next       = 1'b1;
                  frame_count_next = frame_count_reg + 16'd1;
                  state_next       = sync_rise ? IDLE : DONE;
               end else if (sync_rise) begin
                  abort_next = 1'b1;
                  state_next = IDLE;
               end
            end

            DONE: begin
               overrun_next = sclk_fall;
               if (sync_rise) begin
                  state_next = IDLE;
               end
            end

            LOCKOUT: begin
               if (settle_reg == '0 && sync_level) begin
                  state_next = IDLE;
               end
            end

            default: state_next = IDLE;
         endcase
      end

      busy_next = (state_next == SHIFT) || (state_next == DONE);
   end

   always_ff @(posedge dataclk) begin
      if (reset) begin
         // Always resolve through LOCKOUT: it drops to IDLE as soon as the
         // refilled synchronizer shows SYNC high, and otherwise discards the
         // frame that was in flight across the reset.
         state_reg       <= LOCKOUT;
         settle_reg      <= SETTLE_LOAD;
         bit_cnt_reg     <= '0;
         shift_reg       <= '0;
         word_reg        <= 16'h8000;
         twos_reg        <= 16'h0000;
         pd_reg          <= 2'b00;
         frame_count_reg <= 16'h0000;
         valid_reg       <= 1'b0;
         abort_reg       <= 1'b0;
         overrun_reg     <= 1'b0;
         busy_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         settle_reg      <= settle_next;
         bit_cnt_reg     <= bit_cnt_next;
         shift_reg       <= shift_next;
         word_reg        <= word_next;
         twos_reg        <= twos_next;
         pd_reg          <= pd_next;
         frame_count_reg <= frame_count_next;
         valid_reg       <= valid_next;
         abort_reg       <= abort_next;
         overrun_reg     <= overrun_next;
         busy_reg        <= busy_next;
      end
   end

   // Rising SCLK, DIN edges, the SCLK level and the oldest shift bit carry no
   // information for this decoder.
   logic unused_pins;
   assign unused_pins = ^{pin_rise[1:0], pin_fall[0], pin_level[1], shift_reg[FRAME_BITS-1]};

   assign word_out       = word_reg;
   assign word_twos_comp = twos_reg;
   assign pd_out         = pd_reg;
   assign word_valid     = valid_reg;
   assign abort_err      = abort_reg;
   assign overrun_err    = overrun_reg;
   assign frame_count    = frame_count_reg;
   assign busy           = busy_reg;

endmodule

// File: tb/tb_dac_spi_frame_receiver.sv
module tb_dac_spi_frame_receiver;

   import dac_spi_pkg::*;

   logic        dataclk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic        spi_sync_in = 1'b1;
   logic        spi_sclk_in = 1'b1;
   logic        spi_din_in = 1'b0;
   logic [15:0] word_out;
   logic [15:0] word_twos_comp;
   logic [1:0]  pd_out;
   logic        word_valid;
   logic        abort_err;
   logic        overrun_err;
   logic [15:0] frame_count;
   logic        busy;

   always #5 dataclk = ~dataclk;

   dac_spi_frame_receiver #(
      .FRAME_BITS  (24),
      .SYNC_STAGES (2)
   ) dut (
      .dataclk        (dataclk),
      .reset          (reset),
      .enable         (enable),
      .spi_sync_in    (spi_sync_in),
      .spi_sclk_in    (spi_sclk_in),
      .spi_din_in     (spi_din_in),
      .word_out       (word_out),
      .word_twos_comp (word_twos_comp),
      .pd_out         (pd_out),
      .word_valid     (word_valid),
      .abort_err      (abort_err),
      .overrun_err    (overrun_err),
      .frame_count    (frame_count),
      .busy           (busy)
   );

   int checks = 0;
   int errors = 0;

   // Posedge counter and strobe monitor (sampled on the falling edge)
   int cyc = 0;
   int valid_cnt = 0;
   int abort_cnt = 0;
   int ovr_cnt = 0;
   int valid_cyc = 0;

   always @(posedge dataclk) cyc <= cyc + 1;

   always @(negedge dataclk) begin
      if (word_valid) begin
         valid_cnt <= valid_cnt + 1;
         valid_cyc <= cyc;
      end
      if (abort_err)   abort_cnt <= abort_cnt + 1;
      if (overrun_err) ovr_cnt   <= ovr_cnt + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   // Expected state carried between frames
   logic [15:0] exp_word = 16'h8000;
   logic [1:0]  exp_pd   = 2'b00;
   logic [15:0] exp_fc   = 16'h0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clock_edges(input int n, input int phase);
      for (int e = 0; e < n; e++) begin
         spi_din_in = 1'($urandom_range(0, 1));
         repeat (phase) @(negedge dataclk);
         spi_sclk_in = 1'b0;
         repeat (phase) @(negedge dataclk);
         spi_sclk_in = 1'b1;
      end
   endtask

   // One SYNC-framed burst. n_cyc is the index of the first posedge that
   // samples the 24th SCLK low (-1 if there is no 24th edge).
   task automatic send_frame(input logic [23:0] data, input int edges, input int phase,
                             input bit swl, output int n_cyc);
      n_cyc = -1;
      spi_sync_in = 1'b0;
      repeat (phase) @(negedge dataclk);
      for (int e = 0; e < edges; e++) begin
         if (e < 24) spi_din_in = data[23-e];
         else        spi_din_in = 1'($urandom_range(0, 1));
         repeat (phase) @(negedge dataclk);
         spi_sclk_in = 1'b0;
         if (e == 23) n_cyc = cyc + 1;
         if (swl && e == edges - 1) spi_sync_in = 1'b1;
         repeat (phase) @(negedge dataclk);
         spi_sclk_in = 1'b1;
      end
      if (!swl) begin
         repeat (phase) @(negedge dataclk);
         spi_sync_in = 1'b1;
      end
      repeat (8) @(negedge dataclk);
   endtask

   task automatic check_outputs(input string tag, input int dv, input int da, input int dov,
                                input int ev, input int ea, input int eov);
      check({tag, ".valid_pulses"}, dv, ev);
      check({tag, ".abort_pulses"}, da, ea);
      check({tag, ".overrun_pulses"}, dov, eov);
      check({tag, ".word_out"}, word_out, exp_word);
      check({tag, ".word_twos_comp"}, word_twos_comp, {~exp_word[15], exp_word[14:0]});
      check({tag, ".pd_out"}, pd_out, exp_pd);
      check({tag, ".frame_count"}, frame_count, exp_fc);
      check({tag, ".busy_after"}, busy, 1'b0);
   endtask

   // Send a frame and compare against the current expectations
   task automatic run_frame(input string tag, input logic [23:0] data, input int edges,
                            input int phase, input bit swl, input int ev, input int ea, input int eov);
      int v0, a0, o0, n_cyc;
      v0 = valid_cnt; a0 = abort_cnt; o0 = ovr_cnt;
      send_frame(data, edges, phase, swl, n_cyc);
      check_outputs(tag, valid_cnt - v0, abort_cnt - a0, ovr_cnt - o0, ev, ea, eov);
      if (ev == 1 && valid_cnt - v0 == 1)
         check({tag, ".latency"}, valid_cyc - n_cyc, 3);
      $display("frame %-8s data=%06h edges=%0d phase=%0d swl=%0d -> word=%04h pd=%0d fc=%0d valid=%0d abort=%0d ovr=%0d",
               tag, data, edges, phase, swl, word_out, pd_out, frame_count,
               valid_cnt - v0, abort_cnt - a0, ovr_cnt - o0);
   endtask

   // Reference: a frame with at least 24 falling edges yields the first 24
   // bits; fewer edges is an abort that leaves the outputs alone.
   task automatic model_and_run(input string tag, input logic [23:0] data, input int edges,
                                input int phase, input bit swl);
      if (edges >= 24) begin
         exp_word = data[15:0];
         exp_pd   = data[17:16];
         exp_fc   = exp_fc + 16'd1;
         run_frame(tag, data, edges, phase, swl, 1, 0, edges - 24);
      end else begin
         run_frame(tag, data, edges, phase, swl, 0, 1, 0);
      end
   endtask

   typedef struct {
      logic [23:0] data;
      int          edges;
      int          phase;
      bit          swl;
      logic [15:0] exp_word;
      logic [1:0]  exp_pd;
      logic [15:0] exp_fc;
      int          exp_valid;
      int          exp_abort;
      int          exp_ovr;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int v0, a0, o0;

      vecs[0] = '{24'h00C350, 24, 3, 1'b0, 16'hC350, PD_NORMAL,   16'd1, 1, 0, 0};
      vecs[1] = '{24'h030000, 24, 3, 1'b0, 16'h0000, PD_TRISTATE, 16'd2, 1, 0, 0};
      vecs[2] = '{24'h0FFFFF, 17, 3, 1'b0, 16'h0000, PD_TRISTATE, 16'd2, 0, 1, 0};
      vecs[3] = '{24'h001234, 24, 3, 1'b0, 16'h1234, PD_NORMAL,   16'd3, 1, 0, 0};
      vecs[4] = '{24'hABCDEF, 26, 3, 1'b0, 16'hCDEF, PD_TRISTATE, 16'd4, 1, 0, 2};
      vecs[5] = '{24'h018000, 24, 3, 1'b1, 16'h8000, PD_1K,       16'd5, 1, 0, 0};
      vecs[6] = '{24'h02AAAA, 23, 3, 1'b1, 16'h8000, PD_1K,       16'd5, 0, 1, 0};
      vecs[7] = '{24'h0000FF, 24, 2, 1'b0, 16'h00FF, PD_NORMAL,   16'd6, 1, 0, 0};

      // Reset values, checked while reset is still held
      repeat (4) @(negedge dataclk);
      check("reset.word_out", word_out, 16'h8000);
      check("reset.word_twos_comp", word_twos_comp, 16'h0000);
      check("reset.pd_out", pd_out, 2'b00);
      check("reset.strobes", {word_valid, abort_err, overrun_err}, 3'b000);
      check("reset.frame_count", frame_count, 16'h0000);
      check("reset.busy", busy, 1'b0);
      reset = 1'b0;
      repeat (8) @(negedge dataclk);

      for (int i = 0; i < 8; i++) begin
         exp_word = vecs[i].exp_word;
         exp_pd   = vecs[i].exp_pd;
         exp_fc   = vecs[i].exp_fc;
         run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].edges, vecs[i].phase,
                   vecs[i].swl, vecs[i].exp_valid, vecs[i].exp_abort, vecs[i].exp_ovr);
      end

      // Reset in the middle of a frame, released while SYNC is still low
      v0 = valid_cnt; a0 = abort_cnt; o0 = ovr_cnt;
      spi_sync_in = 1'b0;
      repeat (3) @(negedge dataclk);
      clock_edges(8, 3);
      check("midreset.busy_in_frame", busy, 1'b1);
      reset = 1'b1;
      repeat (2) @(negedge dataclk);
      reset = 1'b0;
      clock_edges(10, 3);
      repeat (3) @(negedge dataclk);
      spi_sync_in = 1'b1;
      repeat (8) @(negedge dataclk);
      exp_word = 16'h8000; exp_pd = 2'b00; exp_fc = 16'h0000;
      check_outputs("midreset", valid_cnt - v0, abort_cnt - a0, ovr_cnt - o0, 0, 0, 0);
      $display("frame %-8s reset mid-frame then 10 edges -> word=%04h fc=%0d", "midreset", word_out, frame_count);
      model_and_run("after_rst", 24'h001234, 24, 3, 1'b0);

      // Frame counter wrap
      force dut.frame_count_reg = 16'hFFFF;
      @(negedge dataclk);
      release dut.frame_count_reg;
      exp_fc = 16'hFFFF;
      model_and_run("wrap", 24'h00ABCD, 24, 3, 1'b0);
      check("wrap.frame_count_zero", frame_count, 16'h0000);

      // Receiver disabled for a whole frame: nothing decoded, no strobes
      enable = 1'b0;
      repeat (2) @(negedge dataclk);
      run_frame("disabled", 24'h005555, 24, 3, 1'b0, 0, 0, 0);
      enable = 1'b1;
      repeat (4) @(negedge dataclk);

      // Disable mid-frame, re-enable while SYNC is still low: frame discarded
      v0 = valid_cnt; a0 = abort_cnt; o0 = ovr_cnt;
      spi_sync_in = 1'b0;
      repeat (3) @(negedge dataclk);
      clock_edges(5, 3);
      check("endrop.busy_in_frame", busy, 1'b1);
      enable = 1'b0;
      repeat (4) @(negedge dataclk);
      check("endrop.busy_disabled", busy, 1'b0);
      enable = 1'b1;
      clock_edges(19, 3);
      repeat (3) @(negedge dataclk);
      spi_sync_in = 1'b1;
      repeat (8) @(negedge dataclk);
      check_outputs("endrop", valid_cnt - v0, abort_cnt - a0, ovr_cnt - o0, 0, 0, 0);
      $display("frame %-8s enable dropped mid-frame -> word=%04h fc=%0d", "endrop", word_out, frame_count);

      // DAC generator style stream at minimum SCLK phases, code 0x8000
      for (int i = 0; i < 3; i++)
         model_and_run($sformatf("dac%0d", i), 24'h008000, 24, 2, 1'b0);

      // Randomized frames against the reference
      for (int i = 0; i < 25; i++) begin
         logic [23:0] d;
         int          ed, ph;
         bit          swl;
         d   = 24'($urandom);
         ed  = $urandom_range(18, 27);
         ph  = $urandom_range(2, 4);
         swl = ($urandom_range(0, 3) == 0);
         model_and_run($sformatf("rnd%0d", i), d, ed, ph, swl);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
